aes_iter: RTL and testbench

AES_ITER -- requirements
Module: aes_iter

---
 rtl/aes_iter.sv | 218 +++++++++++++++++++++
 tb/tb_aes_iter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter.sv
// -----------------------------------------------------------------------------
// aes_iter -- iterative AES encryption core, one round per clock.
//
// Parameters
//   KW         key width in bits, 128 or 256
//   NR         round count, derived from KW (10 or 14)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   nreset     asynchronous active-low reset
//   clear      synchronous abort, returns to IDLE and discards the job
//   in_valid   plaintext/key present          in_ready  core can accept a job
//   in_data    128-bit plaintext, byte 0 in [127:120]
//   in_key     KW-bit cipher key, byte 0 in the MSBs
//   out_valid  ciphertext available            out_ready consumer takes it
//   out_data   128-bit ciphertext, held until the next job completes
//   busy       high while a job is in ROUND or DONE
//
// Round keys are produced on the fly from a single key window register:
//   KW=128: key_q holds the previous round key; the current one is expanded
//           from it combinationally and written back.
//   KW=256: key_q holds the last two round keys {K(r-1), K(r)}; round r uses
//           the low half and the window slides by one expanded 128-bit step.
// -----------------------------------------------------------------------------
module aes_iter #(
  parameter  int KW = 256,
  localparam int NR = (KW == 256) ? 14 : 10
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [KW-1:0] in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [2047-8b -: 8]; 2047-8b is exactly {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;
      4'd3: return 8'h08;  4'd4: return 8'h10;  4'd5: return 8'h20;
      4'd6: return 8'h40;  4'd7: return 8'h80;  4'd8: return 8'h1b;
      4'd9: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  // One 4-word expansion step. prev = the four words Nk positions back,
  // last = the most recent word; rot selects RotWord+SubWord+Rcon versus
  // SubWord alone (the Nk=8 odd step).
  function automatic logic [127:0] expand4(input logic [127:0] prev, input logic [31:0] last,
                                           input logic rot, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h0}) : sub_word(last);
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n = row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [KW-1:0]  key_q, key_d, key_next;
  logic [127:0]   blk_q, blk_d, out_data_q, out_data_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [127:0]   round_key, rnd_out;

  if (KW == 128) begin : g_k128
    always_comb begin
      round_key = expand4(key_q, key_q[31:0], 1'b1, rcon(rnd_q - 4'd1));
      key_next  = round_key;
    end
  end else begin : g_k256
    // Odd rounds produce an even-indexed key (RotWord step), Rcon index r/2.
    always_comb begin
      round_key = key_q[127:0];
      key_next  = {key_q[127:0],
                   expand4(key_q[255:128], key_q[31:0], rnd_q[0], rcon(rnd_q >> 1))};
    end
  end

  // NOTE: combinational logic uses blocking '=' so later lines see earlier
  // results within the same evaluation; flops below use non-blocking '<='.
  always_comb begin
    logic [127:0] sr;
    sr      = shift_rows(sub_bytes(blk_q));
    rnd_out = ((rnd_q == 4'(NR)) ? sr : mix_columns(sr)) ^ round_key;
  end

  // NOTE: every _d signal gets its hold value first, so no path through this
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    key_d      = key_q;
    blk_d      = blk_q;
    out_data_d = out_data_q;
    if (clear) begin
      state_d = S_IDLE;
      rnd_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid && in_ready_q) begin
          key_d   = in_key;
          blk_d   = in_data ^ in_key[KW-1 -: 128];
          rnd_d   = 4'd1;
          state_d = S_ROUND;
        end
        S_ROUND: begin
          blk_d = rnd_out;
          key_d = key_next;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == 4'(NR)) begin
            out_data_d = rnd_out;
            rnd_d      = 4'd0;
            state_d    = S_DONE;
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: the key and block registers are plain flops, not a memory, so they
  // take the asynchronous reset like everything else and read 0 after reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      rnd_q       <= 4'd0;
      key_q       <= '0;
      blk_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_iter -- self-checking bench for aes_iter.
// Two instances share clock, reset, clear and plaintext: dut_a (KW=256) and
// dut_b (KW=128). sel256 picks which one a job is steered to and observed on.
// The reference model runs the textbook FIPS-197 cipher on byte matrices, with
// an S-box derived from GF(2^8) inversion plus the affine map.
// -----------------------------------------------------------------------------
module tb_aes_iter;

  logic         clk, nreset, clear;
  logic         sel256, drv_valid, drv_ready;
  logic [127:0] in_data;
  logic [255:0] key_in;

  logic         a_in_ready, a_out_valid, a_busy;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [127:0] a_out_data, b_out_data;

  logic         s_in_ready, s_out_valid, s_busy;
  logic [127:0] s_out_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb [256];

  aes_iter #(.KW(256)) dut_a (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(drv_valid & sel256), .in_ready(a_in_ready),
    .in_data(in_data), .in_key(key_in),
    .out_valid(a_out_valid), .out_ready(drv_ready & sel256),
    .out_data(a_out_data), .busy(a_busy)
  );

  aes_iter #(.KW(128)) dut_b (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(drv_valid & ~sel256), .in_ready(b_in_ready),
    .in_data(in_data), .in_key(key_in[255:128]),
    .out_valid(b_out_valid), .out_ready(drv_ready & ~sel256),
    .out_data(b_out_data), .busy(b_busy)
  );

  assign s_in_ready  = sel256 ? a_in_ready  : b_in_ready;
  assign s_out_valid = sel256 ? a_out_valid : b_out_valid;
  assign s_busy      = sel256 ? a_busy      : b_busy;
  assign s_out_data  = sel256 ? a_out_data  : b_out_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // key is left-aligned: a 128-bit key lives in key[255:128].
  function automatic logic [127:0] model_encrypt(input logic [255:0] key, input bit w256,
                                                 input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] ct;
    int nk, nr;
    nk = w256 ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word_m(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sb[s[(r)][(c+r)%4]];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
          t[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = t[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- job driver ----------------
  // Entered and left at #1 after a rising edge with the selected DUT idle.
  task automatic do_job(input bit w256, input logic [255:0] key, input logic [127:0] pt,
                        input logic [127:0] exp, input int hold, input string name);
    int nr, cyc;
    nr = w256 ? 14 : 10;
    sel256 = w256;
    n_vec++;
    if (s_in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s start in_ready: got %b want 1", name, s_in_ready);
    end
    in_data = pt; key_in = key; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    in_data = rand256()[127:0];
    key_in  = rand256();
    n_vec++;
    if ({s_busy, s_in_ready} !== 2'b10) begin
      n_err++; $display("FAIL %s accept busy/in_ready: got %b want 10", name, {s_busy, s_in_ready});
    end
    cyc = 0;
    while (s_out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (cyc == nr / 2) begin in_data = rand256()[127:0]; key_in = rand256(); end
    end
    n_vec++;
    if (cyc != nr) begin
      n_err++; $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, nr);
    end
    n_vec++;
    if (s_out_data !== exp) begin
      n_err++; $display("FAIL %s out_data: got %h want %h", name, s_out_data, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin in_data = rand256()[127:0]; key_in = rand256(); end
      n_vec++;
      if ({s_out_valid, s_in_ready, s_out_data} !== {2'b10, exp}) begin
        n_err++;
        $display("FAIL %s backpressure cycle %0d: got ov=%b ir=%b data=%h want ov=1 ir=0 data=%h",
                 name, i, s_out_valid, s_in_ready, s_out_data, exp);
      end
    end
    // Drain; a simultaneous in_valid must not start a job on the same edge.
    drv_ready = 1'b1; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0; drv_valid = 1'b0;
    n_vec++;
    if ({s_out_valid, s_in_ready, s_busy} !== 3'b010) begin
      n_err++; $display("FAIL %s drain ov/ir/busy: got %b want 010", name,
                        {s_out_valid, s_in_ready, s_busy});
    end
    n_vec++;
    if (s_out_data !== exp) begin
      n_err++; $display("FAIL %s idle hold out_data: got %h want %h", name, s_out_data, exp);
    end
  endtask

  // ---------------- tests ----------------
  localparam logic [255:0] K128_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K128_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K256_B = 256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check_reset_values(input string name);
    n_vec++;
    if ({a_in_ready, a_out_valid, a_busy, a_out_data} !== {3'b100, 128'h0}) begin
      n_err++; $display("FAIL %s dut256: got ir=%b ov=%b busy=%b data=%h want 1 0 0 0", name,
                        a_in_ready, a_out_valid, a_busy, a_out_data);
    end
    n_vec++;
    if ({b_in_ready, b_out_valid, b_busy, b_out_data} !== {3'b100, 128'h0}) begin
      n_err++; $display("FAIL %s dut128: got ir=%b ov=%b busy=%b data=%h want 1 0 0 0", name,
                        b_in_ready, b_out_valid, b_busy, b_out_data);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    #1 nreset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_release");
  endtask

  task automatic test_kat();
    do_job(1'b0, K128_A, PT_A, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "kat128_a");
    do_job(1'b0, K128_B, PT_B, 128'h3925841d02dc09fbdc118597196a0b32, 2, "kat128_b");
    do_job(1'b1, K256_A, PT_A, 128'h8ea2b7ca516745bfeafc49904b496089, 0, "kat256_a");
    do_job(1'b1, K256_B, PT_B, 128'h1a6e6c2c662e7da6501ffb62bc9e93f3, 1, "kat256_b");
  endtask

  task automatic test_backpressure();
    do_job(1'b1, K256_A, PT_A, 128'h8ea2b7ca516745bfeafc49904b496089, 20, "bp256");
    do_job(1'b0, K128_A, PT_A, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, "bp128");
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt;
    bit           w;
    for (int i = 0; i < 16; i++) begin
      w   = 1'($urandom_range(0, 1));
      key = rand256();
      pt  = rand256()[127:0];
      do_job(w, key, pt, model_encrypt(key, w, pt), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_clear();
    bit seen;
    int cyc;
    // Abort while round 5 is being computed.
    sel256 = 1'b1;
    in_data = PT_B; key_in = K256_B; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++;
    if ({a_out_valid, a_in_ready, a_busy} !== 3'b010) begin
      n_err++; $display("FAIL clear_round5 ov/ir/busy: got %b want 010", {a_out_valid, a_in_ready, a_busy});
    end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; seen |= a_out_valid; end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL clear_no_output: out_valid seen=%b want 0", seen);
    end
    // clear wins over an IDLE handshake.
    in_data = PT_A; key_in = K256_A; drv_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0; clear = 1'b0;
    n_vec++;
    if ({a_busy, a_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL clear_idle_accept busy/ir: got %b want 01", {a_busy, a_in_ready});
    end
    // clear while DONE is waiting for out_ready.
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    cyc = 0;
    while (a_out_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (cyc != 14) begin
      n_err++; $display("FAIL clear_done latency: got %0d want 14", cyc);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++;
    if ({a_out_valid, a_in_ready, a_out_data} !== {2'b01, 128'h8ea2b7ca516745bfeafc49904b496089}) begin
      n_err++; $display("FAIL clear_done: got ov=%b ir=%b data=%h want ov=0 ir=1 data=8ea2b7ca...",
                        a_out_valid, a_in_ready, a_out_data);
    end
    do_job(1'b1, K256_B, PT_B, 128'h1a6e6c2c662e7da6501ffb62bc9e93f3, 0, "after_clear");
  endtask

  task automatic test_async_reset();
    sel256 = 1'b0;
    in_data = PT_B; key_in = K128_B; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #3 nreset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("async_release");
    do_job(1'b0, K128_A, PT_A, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "b2b_128_a");
    do_job(1'b0, K128_B, PT_B, 128'h3925841d02dc09fbdc118597196a0b32, 0, "b2b_128_b");
    do_job(1'b1, K256_A, PT_A, 128'h8ea2b7ca516745bfeafc49904b496089, 0, "b2b_256_a");
    do_job(1'b1, K256_B, PT_B, 128'h1a6e6c2c662e7da6501ffb62bc9e93f3, 0, "b2b_256_b");
  endtask

  initial begin
    nreset = 1'b0; clear = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
    sel256 = 1'b1; in_data = '0; key_in = '0;
    init_sbox();
    test_reset();
    test_kat();
    test_backpressure();
    test_random();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
